// File: rtl/key_encoder10to4_pkg.sv
// Shared definitions for the keypad encoder: widths, state encoding and the
// lowest-index-wins priority encoder.
package key_pkg;
  localparam int KEY_NUM = 10;
  localparam int CODE_W  = 4;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_PRESS_DB   = 2'd1;
  localparam logic [1:0] ST_HELD       = 2'd2;
  localparam logic [1:0] ST_RELEASE_DB = 2'd3;

  typedef enum logic [1:0] {
    KS_IDLE       = ST_IDLE,
    KS_PRESS_DB   = ST_PRESS_DB,
    KS_HELD       = ST_HELD,
    KS_RELEASE_DB = ST_RELEASE_DB
  } key_state_e;

  // Scanning from the top down leaves the lowest asserted index as the result.
  function automatic logic [CODE_W-1:0] enc(input logic [KEY_NUM-1:0] p);
    logic [CODE_W-1:0] c;
    c = '0;
    for (int i = KEY_NUM - 1; i >= 0; i--) begin
      if (p[i]) c = CODE_W'(i);
    end
    return c;
  endfunction

  function automatic logic multi_hot(input logic [KEY_NUM-1:0] p);
    return (p & (p - KEY_NUM'(1))) != '0;
  endfunction
endpackage

// File: rtl/key_encoder10to4_sync2.sv
// Two-flop synchronizer of configurable width with synchronous active-high
// clear; usable for any asynchronous front-panel input.
module key_sync2 #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] s1_q, s1_d;
  logic [W-1:0] s2_q, s2_d;

  always_comb begin
    s1_d = i_d;
    s2_d = s1_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign o_q = s2_q;
endmodule

// File: rtl/key_encoder10to4.sv
// Debounced 10-key to BCD encoder with one-cycle strobe per accepted press.
// Optional auto-repeat while held is enabled by defining KEY_REPEAT_EN.
module key_encoder10to4
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int CNT_W           = 16,
  parameter int REPEAT_CYCLES   = 1000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [KEY_NUM-1:0] i_keys,
  output logic [CODE_W-1:0]  o_code,
  output logic               o_valid,
  output logic               o_pressed,
  output logic               o_multi,
  output logic [1:0]         o_dbg_state
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [KEY_NUM-1:0] s_keys;
  key_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [KEY_NUM-1:0] pat_q, pat_d;
  logic               valid_q, valid_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic               multi_q, multi_d;
  logic               pressed_q, pressed_d;

`ifdef KEY_REPEAT_EN
  localparam int RPT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RPT_W-1:0] RPT_MAX = RPT_W'(REPEAT_CYCLES - 1);
  logic [RPT_W-1:0] rpt_q, rpt_d;
`else
  logic rpt_unused;
  assign rpt_unused = (REPEAT_CYCLES > 0);
`endif

  key_sync2 #(.W(KEY_NUM)) u_sync (
    .i_clk (i_clk),
    .i_clr (i_rst),
    .i_d   (i_keys),
    .o_q   (s_keys)
  );

  // o_valid is a single-cycle strobe with no back-pressure: o_code/o_multi
  // are meaningful in that cycle and hold their value until the next strobe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    valid_d = 1'b0;
    code_d  = code_q;
    multi_d = multi_q;
`ifdef KEY_REPEAT_EN
    rpt_d   = rpt_q;
`endif
    case (state_q)
      KS_IDLE: begin
        if (s_keys != '0) begin
          pat_d   = s_keys;
          cnt_d   = '0;
          state_d = KS_PRESS_DB;
        end
      end
      KS_PRESS_DB: begin
        if (s_keys != pat_q) begin
          cnt_d   = '0;
          state_d = KS_IDLE;
        end else if (cnt_q == CNT_MAX) begin
          state_d = KS_HELD;
          valid_d = 1'b1;
          code_d  = enc(pat_q);
          multi_d = multi_hot(pat_q);
`ifdef KEY_REPEAT_EN
          rpt_d   = '0;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      KS_HELD: begin
        if (s_keys == '0) begin
          cnt_d   = '0;
          state_d = KS_RELEASE_DB;
        end
`ifdef KEY_REPEAT_EN
        else if (rpt_q == RPT_MAX) begin
          valid_d = 1'b1;
          rpt_d   = '0;
        end else begin
          rpt_d = rpt_q + RPT_W'(1);
        end
`endif
      end
      KS_RELEASE_DB: begin
        if (s_keys != '0) begin
          state_d = KS_HELD;
`ifdef KEY_REPEAT_EN
          rpt_d   = '0;
`endif
        end else if (cnt_q == CNT_MAX) begin
          state_d = KS_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = KS_IDLE;
    endcase
    pressed_d = (state_d == KS_HELD) || (state_d == KS_RELEASE_DB);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= KS_IDLE;
      cnt_q     <= '0;
      pat_q     <= '0;
      valid_q   <= 1'b0;
      code_q    <= '0;
      multi_q   <= 1'b0;
      pressed_q <= 1'b0;
`ifdef KEY_REPEAT_EN
      rpt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pat_q     <= pat_d;
      valid_q   <= valid_d;
      code_q    <= code_d;
      multi_q   <= multi_d;
      pressed_q <= pressed_d;
`ifdef KEY_REPEAT_EN
      rpt_q     <= rpt_d;
`endif
    end
  end

  assign o_code      = code_q;
  assign o_valid     = valid_q;
  assign o_pressed   = pressed_q;
  assign o_multi     = multi_q;
  assign o_dbg_state = state_q;
endmodule

// File: tb/tb_key_encoder10to4.sv
// Bench for key_encoder10to4: run-length reference model checked every cycle,
// plus directed presses with hand-computed strobe timing and codes.
module tb_key_encoder10to4;
  import key_pkg::*;

  localparam int DB  = 4;
  localparam int REP = 8;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [9:0] i_keys;
  logic [3:0] o_code;
  logic       o_valid, o_pressed, o_multi;
  logic [1:0] o_dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  key_encoder10to4 #(
    .DEBOUNCE_CYCLES (DB),
    .CNT_W           (16),
    .REPEAT_CYCLES   (REP)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_keys      (i_keys),
    .o_code      (o_code),
    .o_valid     (o_valid),
    .o_pressed   (o_pressed),
    .o_multi     (o_multi),
    .o_dbg_state (o_dbg_state)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] lowest(input logic [9:0] v);
    for (int i = 0; i < 10; i++) if (v[i]) return 4'(i);
    return 4'd0;
  endfunction

  // Reference model: a press is accepted after DB+1 consecutive identical
  // nonzero synchronized samples, a release after DB+1 consecutive zeros.
  logic [9:0] m_s1, m_s2, m_pat, m_s;
  int         m_run, m_zrun, m_rpt;
  bit         m_held, m_live = 1'b0;
  logic       m_valid, m_pressed, m_multi;
  logic [3:0] m_code;

  always @(posedge i_clk) begin
    if (i_rst) begin
      m_s1 = '0; m_s2 = '0; m_pat = '0;
      m_run = 0; m_zrun = 0; m_rpt = 0; m_held = 1'b0;
      m_valid = 1'b0; m_pressed = 1'b0; m_multi = 1'b0; m_code = '0;
      m_live = 1'b1;
    end else begin
      m_s = m_s2;
      m_valid = 1'b0;
      if (!m_held) begin
        if (m_run == 0) begin
          if (m_s != '0) begin m_pat = m_s; m_run = 1; end
        end else if (m_s != m_pat) begin
          m_run = 0;
        end else begin
          m_run++;
          if (m_run == DB + 1) begin
            m_held = 1'b1; m_valid = 1'b1;
            m_code = lowest(m_s); m_multi = ($countones(m_s) > 1);
            m_run = 0; m_zrun = 0; m_rpt = 0;
          end
        end
      end else begin
        if (m_s == '0) begin
          m_zrun++;
          if (m_zrun == DB + 1) begin m_held = 1'b0; m_zrun = 0; end
        end else if (m_zrun > 0) begin
          m_zrun = 0; m_rpt = 0;
        end else begin
`ifdef KEY_REPEAT_EN
          m_rpt++;
          if (m_rpt == REP) begin m_valid = 1'b1; m_rpt = 0; end
`endif
        end
      end
      m_pressed = m_held;
      m_s2 = m_s1;
      m_s1 = i_keys;
    end
  end

  always @(negedge i_clk) begin
    if (m_live) begin
      check("mdl_valid",   32'(o_valid),   32'(m_valid));
      check("mdl_pressed", 32'(o_pressed), 32'(m_pressed));
      check("mdl_code",    32'(o_code),    32'(m_code));
      check("mdl_multi",   32'(o_multi),   32'(m_multi));
    end
  end

  // Log of observed strobes for the directed checks.
  int         strobe_cnt = 0;
  logic [3:0] strobe_codes[$];
  always @(negedge i_clk) begin
    if (m_live && o_valid === 1'b1) begin
      strobe_cnt++;
      strobe_codes.push_back(o_code);
    end
  end

  task automatic drive(input logic [9:0] k, input int n);
    i_keys = k;
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  logic [3:0] exp_q[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [9:0] v;
    logic [3:0] got;

    // Reset with all keys asserted.
    i_rst = 1'b1;
    i_keys = 10'h3FF;
    for (int c = 0; c < 3; c++) begin
      @(posedge i_clk); #1;
      check("rst_valid",   32'(o_valid),     32'd0);
      check("rst_pressed", 32'(o_pressed),   32'd0);
      check("rst_code",    32'(o_code),      32'd0);
      check("rst_multi",   32'(o_multi),     32'd0);
      check("rst_state",   32'(o_dbg_state), 32'(ST_IDLE));
    end
    i_rst = 1'b0;
    drive(10'h3FF, 1);
    check("post_rst_valid",   32'(o_valid),   32'd0);
    check("post_rst_pressed", 32'(o_pressed), 32'd0);
    drive(10'h3FF, 2);
    drive(10'h000, 12);
    check("rst_no_strobe", 32'(strobe_cnt), 32'd0);

    // Clean press of key 5: strobe exactly on cycle 7.
    base = strobe_cnt;
    i_keys = 10'b00_0010_0000;
    for (int c = 1; c <= 20; c++) begin
      @(posedge i_clk); #1;
      if (c == 6) check("clean_early", 32'(o_valid), 32'd0);
      if (c == 7) begin
        check("clean_valid", 32'(o_valid), 32'd1);
        check("clean_code",  32'(o_code),  32'd5);
        check("clean_multi", 32'(o_multi), 32'd0);
      end
      if (c == 8) check("clean_pressed", 32'(o_pressed), 32'd1);
    end
    i_keys = 10'h000;
    for (int c = 1; c <= 7; c++) begin
      @(posedge i_clk); #1;
      if (c == 6) check("rel_still_pressed", 32'(o_pressed), 32'd1);
      if (c == 7) check("rel_pressed_low",   32'(o_pressed), 32'd0);
    end
    check("clean_one_strobe", 32'(strobe_cnt - base), 32'd1);
    drive(10'h000, 5);

    // Bouncing key 3, then stable.
    base = strobe_cnt;
    v = 10'b00_0000_1000;
    drive(v, 1); drive(v, 1); drive('0, 1);
    drive(v, 1); drive(v, 1); drive('0, 1);
    check("bounce_no_strobe", 32'(strobe_cnt - base), 32'd0);
    i_keys = v;
    for (int c = 1; c <= 7; c++) begin
      @(posedge i_clk); #1;
      if (c == 7) begin
        check("bounce_valid", 32'(o_valid), 32'd1);
        check("bounce_code",  32'(o_code),  32'd3);
      end
    end
    drive(v, 10);
    drive('0, 12);
    check("bounce_one_strobe", 32'(strobe_cnt - base), 32'd1);

    // Keys 2 and 9 together, then key 9 alone.
    i_keys = 10'b10_0000_0100;
    for (int c = 1; c <= 12; c++) begin
      @(posedge i_clk); #1;
      if (c == 7) begin
        check("multi_valid", 32'(o_valid), 32'd1);
        check("multi_code",  32'(o_code),  32'd2);
        check("multi_flag",  32'(o_multi), 32'd1);
      end
    end
    drive('0, 12);
    i_keys = 10'b10_0000_0000;
    for (int c = 1; c <= 12; c++) begin
      @(posedge i_clk); #1;
      if (c == 7) begin
        check("k9_code",  32'(o_code),  32'd9);
        check("k9_multi", 32'(o_multi), 32'd0);
      end
    end
    drive('0, 12);

    // Key 7 with a one-cycle release glitch.
    base = strobe_cnt;
    drive(10'h080, 12);
    drive(10'h000, 1);
    drive(10'h080, 4);
    check("glitch_pressed", 32'(o_pressed), 32'd1);
    drive(10'h080, 8);
    check("glitch_state", 32'(o_dbg_state), 32'(ST_HELD));
    check("glitch_one_strobe", 32'(strobe_cnt - base), 32'd1);
    drive('0, 12);

    // Reset in the middle of a press debounce aborts it.
    base = strobe_cnt;
    drive(10'h010, 5);
    i_rst = 1'b1;
    drive('0, 1);
    i_rst = 1'b0;
    drive('0, 10);
    check("midrst_no_strobe", 32'(strobe_cnt - base), 32'd0);

    // Sweep keys 0..9.
    base = strobe_cnt;
    for (int k = 0; k < 10; k++) begin
      exp_q.push_back(4'(k));
      drive(10'd1 << k, 10);
      drive('0, 10);
    end
    check("sweep_count", 32'(strobe_cnt - base), 32'd10);
    for (int k = 0; k < 10; k++) begin
      got = strobe_codes[base + k];
      check("sweep_code", 32'(got), 32'(exp_q.pop_front()));
    end

    // Key 1 held 40 cycles.
    base = strobe_cnt;
    drive(10'h002, 40);
    drive('0, 12);
`ifdef KEY_REPEAT_EN
    check("repeat_count", 32'(strobe_cnt - base), 32'd5);
`else
    check("repeat_count", 32'(strobe_cnt - base), 32'd1);
`endif
    for (int k = base; k < strobe_cnt; k++) begin
      got = strobe_codes[k];
      check("repeat_code", 32'(got), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
